// File: rtl/hazard_scoreboard_pkg.sv
// hazard_scoreboard_pkg: shared pipeline slot types and constants
package hazard_scoreboard_pkg;
  localparam int REG_W = 4;
  typedef struct packed {
    logic             valid;
    logic             wb_en;
    logic             mem_r_en;
    logic [REG_W-1:0] dest;
  } slot_t;
  localparam slot_t BUBBLE = '0;
endpackage

// File: rtl/hazard_scoreboard_match.sv
// hazard_match: flags a pipeline slot that writes the given source register
module hazard_match
  import hazard_scoreboard_pkg::*;
(
  input  slot_t            slot,
  input  logic [REG_W-1:0] src,
  input  logic             use_src,
  output logic             hit
);
  assign hit = use_src & slot.valid & slot.wb_en & (slot.dest == src);
endmodule

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight writes and raises IF/ID stalls
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             freeze,
  input  logic             flush,
  input  logic             fwd_en,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_use_src1,
  input  logic             id_use_src2,
  input  logic             id_wb_en,
  input  logic             id_mem_r_en,
  input  logic [REG_W-1:0] id_dest,
  output logic             hazard,
  output logic             mem_wb,
  output logic [REG_W-1:0] mem_dest,
  output logic             wb_wb,
  output logic [REG_W-1:0] wb_dest,
  output logic [CNT_W-1:0] stall_count
);
  slot_t ex, mem, wb, id_slot;
  logic use1, use2, hit_ex1, hit_ex2, hit_mem1, hit_mem2;
  assign use1 = id_valid & id_use_src1;
  assign use2 = id_valid & id_use_src2;
  assign id_slot = {id_valid, id_wb_en, id_mem_r_en, id_dest};
  hazard_match u_ex1  (.slot(ex),  .src(id_src1), .use_src(use1), .hit(hit_ex1));
  hazard_match u_ex2  (.slot(ex),  .src(id_src2), .use_src(use2), .hit(hit_ex2));
  hazard_match u_mem1 (.slot(mem), .src(id_src1), .use_src(use1), .hit(hit_mem1));
  hazard_match u_mem2 (.slot(mem), .src(id_src2), .use_src(use2), .hit(hit_mem2));
  assign hazard = fwd_en ? ((hit_ex1 | hit_ex2) & ex.mem_r_en)
                         : (hit_ex1 | hit_ex2 | hit_mem1 | hit_mem2);
  assign mem_wb   = mem.valid & mem.wb_en;
  assign mem_dest = mem.dest;
  assign wb_wb    = wb.valid & wb.wb_en;
  assign wb_dest  = wb.dest;
  // Shift slots down the pipe, injecting a bubble into EX on stall or flush
  always_ff @(posedge clk) begin
    if (rst) begin
      ex          <= BUBBLE;
      mem         <= BUBBLE;
      wb          <= BUBBLE;
      stall_count <= '0;
    end else if (!freeze) begin
      ex  <= (flush | hazard) ? BUBBLE : id_slot;
      mem <= ex;
      wb  <= mem;
      if (hazard && !(&stall_count)) stall_count <= stall_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: table, directed and randomized checks of the scoreboard
module tb_hazard_scoreboard;
  localparam int CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;
  logic clk = 1'b0;
  logic rst, freeze, flush, fwd_en, id_valid, id_use_src1, id_use_src2, id_wb_en, id_mem_r_en;
  logic [3:0] id_src1, id_src2, id_dest, mem_dest, wb_dest;
  logic hazard, mem_wb, wb_wb;
  logic [CNT_W-1:0] stall_count;
  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hazard_scoreboard #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .fwd_en(fwd_en),
    .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_use_src1(id_use_src1), .id_use_src2(id_use_src2), .id_wb_en(id_wb_en),
    .id_mem_r_en(id_mem_r_en), .id_dest(id_dest), .hazard(hazard),
    .mem_wb(mem_wb), .mem_dest(mem_dest), .wb_wb(wb_wb), .wb_dest(wb_dest),
    .stall_count(stall_count)
  );

  // ctl = {rst,freeze,flush,fwd_en}; ins = {valid,use1,use2,wb_en,mem_r_en}; e = {hazard,mem_wb,wb_wb}
  typedef struct {
    logic [3:0] ctl;
    logic [4:0] ins;
    logic [3:0] s1, s2, d;
    logic       chk;
    logic [2:0] e;
    logic [3:0] md, wd;
    int         cnt;
  } vec_t;

  // In-flight producers indexed by distance from decode (1=EX, 2=MEM, 3=WB)
  typedef struct { bit v; bit w; bit ld; int d; } prod_t;
  prod_t inflight[1:3];
  int m_cnt = 0;

  function automatic vec_t v(input logic [3:0] ctl, input logic [4:0] ins,
                             input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] d,
                             input logic [2:0] e, input logic [3:0] md, input logic [3:0] wd,
                             input int cnt);
    vec_t r;
    r.ctl = ctl; r.ins = ins; r.s1 = s1; r.s2 = s2; r.d = d;
    r.chk = ~ctl[3]; r.e = e; r.md = md; r.wd = wd; r.cnt = cnt;
    return r;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // A source is ready once its producer is far enough ahead: ALU results
  // forward from EX, loads from MEM, and without forwarding only from WB.
  function automatic bit model_hazard();
    bit h = 0;
    for (int k = 1; k <= 3; k++) begin
      int ready = fwd_en ? (inflight[k].ld ? 2 : 1) : 3;
      if (inflight[k].v && inflight[k].w && k < ready &&
          ((id_valid && id_use_src1 && inflight[k].d == int'(id_src1)) ||
           (id_valid && id_use_src2 && inflight[k].d == int'(id_src2))))
        h = 1;
    end
    return h;
  endfunction

  task automatic model_edge(input bit h);
    if (rst) begin
      for (int k = 1; k <= 3; k++) inflight[k] = '{0, 0, 0, 0};
      m_cnt = 0;
    end else if (!freeze) begin
      if (h && m_cnt < CNT_MAX) m_cnt++;
      inflight[3] = inflight[2];
      inflight[2] = inflight[1];
      inflight[1] = (flush || h) ? '{0, 0, 0, 0}
                                 : '{id_valid, id_wb_en, id_mem_r_en, int'(id_dest)};
    end
  endtask

  task automatic apply(input vec_t r, input string tag, input bit vs_model);
    bit mh;
    {rst, freeze, flush, fwd_en} = r.ctl;
    {id_valid, id_use_src1, id_use_src2, id_wb_en, id_mem_r_en} = r.ins;
    id_src1 = r.s1; id_src2 = r.s2; id_dest = r.d;
    #1;
    mh = model_hazard();
    if (r.chk) begin
      check({tag, ".hazard"}, hazard, r.e[2]);
      check({tag, ".mem_wb"}, mem_wb, r.e[1]);
      check({tag, ".mem_dest"}, mem_dest, r.md);
      check({tag, ".wb_wb"}, wb_wb, r.e[0]);
      check({tag, ".wb_dest"}, wb_dest, r.wd);
      check({tag, ".stall_count"}, stall_count, r.cnt);
    end
    if (vs_model) begin
      check({tag, ".hazard"}, hazard, mh);
      check({tag, ".mem_wb"}, mem_wb, inflight[2].v && inflight[2].w);
      check({tag, ".mem_dest"}, mem_dest, inflight[2].d);
      check({tag, ".wb_wb"}, wb_wb, inflight[3].v && inflight[3].w);
      check({tag, ".wb_dest"}, wb_dest, inflight[3].d);
      check({tag, ".stall_count"}, stall_count, m_cnt);
    end
    @(posedge clk);
    model_edge(mh);
    #1;
  endtask

  initial begin
    vec_t tbl[$];
    vec_t rs, ldr3, add4, nop, add2, sub5;
    rs   = v(4'b1000, 5'b00000, 0, 0, 0, 3'b000, 0, 0, 0);
    // load-use with forwarding
    tbl.push_back(rs);
    tbl.push_back(v(4'b0001, 5'b10011, 0, 0, 3, 3'b000, 0, 0, 0));
    tbl.push_back(v(4'b0001, 5'b11110, 3, 1, 4, 3'b100, 0, 0, 0));
    tbl.push_back(v(4'b0001, 5'b11110, 3, 1, 4, 3'b010, 3, 0, 1));
    tbl.push_back(v(4'b0001, 5'b00000, 0, 0, 0, 3'b001, 0, 3, 1));
    // RAW without forwarding: two stall cycles
    tbl.push_back(rs);
    tbl.push_back(v(4'b0000, 5'b10010, 0, 0, 2, 3'b000, 0, 0, 0));
    tbl.push_back(v(4'b0000, 5'b11110, 2, 0, 5, 3'b100, 0, 0, 0));
    tbl.push_back(v(4'b0000, 5'b11110, 2, 0, 5, 3'b110, 2, 0, 1));
    tbl.push_back(v(4'b0000, 5'b11110, 2, 0, 5, 3'b001, 0, 2, 2));
    tbl.push_back(v(4'b0000, 5'b00000, 0, 0, 0, 3'b000, 0, 0, 2));
    // ALU RAW with forwarding: no stall
    tbl.push_back(rs);
    tbl.push_back(v(4'b0001, 5'b10010, 0, 0, 2, 3'b000, 0, 0, 0));
    tbl.push_back(v(4'b0001, 5'b11110, 2, 0, 5, 3'b000, 0, 0, 0));
    tbl.push_back(v(4'b0001, 5'b00000, 0, 0, 0, 3'b010, 2, 0, 0));
    tbl.push_back(v(4'b0001, 5'b00000, 0, 0, 0, 3'b011, 5, 2, 0));
    // unused source matching an EX load
    tbl.push_back(v(4'b0001, 5'b10011, 0, 0, 7, 3'b001, 0, 5, 0));
    tbl.push_back(v(4'b0001, 5'b10010, 7, 7, 6, 3'b000, 0, 0, 0));
    // register 0 is a real register
    tbl.push_back(rs);
    tbl.push_back(v(4'b0000, 5'b10010, 0, 0, 0, 3'b000, 0, 0, 0));
    tbl.push_back(v(4'b0000, 5'b10110, 9, 0, 1, 3'b100, 0, 0, 0));
    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], $sformatf("row%0d", i), 1'b0);

    // freeze during a load-use hazard
    ldr3 = v(4'b0001, 5'b10011, 0, 0, 3, 3'b000, 0, 0, 0);
    add4 = v(4'b0001, 5'b11110, 3, 1, 4, 3'b100, 0, 0, 0);
    apply(rs, "frz", 1'b0);
    apply(ldr3, "frz.ldr", 1'b0);
    for (int i = 0; i < 3; i++)
      apply(v(4'b0101, 5'b11110, 3, 1, 4, 3'b100, 0, 0, 0), $sformatf("frz.hold%0d", i), 1'b0);
    apply(add4, "frz.release", 1'b0);
    apply(v(4'b0001, 5'b11110, 3, 1, 4, 3'b010, 3, 0, 1), "frz.after", 1'b0);

    // flush discards the ID instruction
    nop = v(4'b0001, 5'b00000, 0, 0, 0, 3'b000, 0, 0, 0);
    apply(rs, "flush", 1'b0);
    apply(v(4'b0011, 5'b10010, 0, 0, 2, 3'b000, 0, 0, 0), "flush.id", 1'b0);
    apply(nop, "flush.ex", 1'b0);
    apply(nop, "flush.mem", 1'b0);
    apply(nop, "flush.wb", 1'b0);

    // reset in the middle of a stall
    add2 = v(4'b0000, 5'b10010, 0, 0, 2, 3'b000, 0, 0, 0);
    sub5 = v(4'b0000, 5'b11110, 2, 0, 5, 3'b100, 0, 0, 0);
    apply(rs, "rstmid", 1'b0);
    apply(add2, "rstmid.add", 1'b0);
    apply(sub5, "rstmid.stall", 1'b0);
    apply(v(4'b1000, 5'b11110, 2, 0, 5, 3'b000, 0, 0, 0), "rstmid.rst", 1'b0);
    apply(v(4'b0000, 5'b11110, 2, 0, 5, 3'b000, 0, 0, 0), "rstmid.after", 1'b0);

    // randomized traffic against the reference model
    apply(rs, "rnd.rst", 1'b0);
    for (int i = 0; i < 4000; i++) begin
      vec_t r;
      r.ctl = {($urandom_range(255) == 0), ($urandom_range(7) == 0),
               ($urandom_range(7) == 0), 1'($urandom_range(1))};
      r.ins = 5'($urandom);
      r.s1 = 4'($urandom_range(3));
      r.s2 = 4'($urandom_range(3));
      r.d = 4'($urandom_range(3));
      r.chk = 1'b0; r.e = '0; r.md = '0; r.wd = '0; r.cnt = 0;
      apply(r, $sformatf("rnd%0d", i), 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Tracks in-flight register writes for the 5-stage pipeline in its own EX/MEM/WB shadow slots. Produces the mem/wb write-enable and destination tags that the forwarding unit consumes.
- Raises a combinational hazard (stall) to IF/ID when a decode-stage source cannot be covered by forwarding.
- Supplies the fwd_en=0 fallback: stall on any RAW dependency.
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
- REG_W, 4, register index width.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  pipeline clock.
- rst  in  1  synchronous, active-high reset.
- freeze  in  1  external hold (memory wait); all slots hold.
- flush  in  1  branch taken; the ID entry is discarded.
- fwd_en  in  1  1 = forwarding active, 0 = stall on every RAW.
- id_valid  in  1  ID stage holds a real instruction.
- id_src1  in  REG_W  first source register (Rn).
- id_src2  in  REG_W  second source register (Rm/Rd for store).
- id_use_src1  in  1  instruction reads src1.
- id_use_src2  in  1  instruction reads src2.
- id_wb_en  in  1  instruction writes the register file.
- id_mem_r_en  in  1  instruction is a load.
- id_dest  in  REG_W  destination register.
- hazard  out  1  stall IF/ID and insert a bubble into EX (combinational).
- mem_wb  out  1  MEM slot write enable, to the forwarding unit.
- mem_dest  out  REG_W  MEM slot destination.
- wb_wb  out  1  WB slot write enable.
- wb_dest  out  REG_W  WB slot destination.
- stall_count  out  CNT_W  cycles with hazard=1 and freeze=0, saturating.

Behaviour:
- Slot contents: {valid, wb_en, mem_r_en, dest}, one slot each for EX, MEM, WB. A bubble is all-zero.
- Reset (rst=1 at posedge): all slots become bubbles; stall_count=0. hazard, mem_wb, wb_wb and the dest outputs are 0 in the following cycle.
- Outputs: mem_wb = MEM.valid & MEM.wb_en; mem_dest = MEM.dest. wb_wb and wb_dest are defined the same way from the WB slot. These are registered slot fields with no extra logic.
- Match(slot, s) = slot.valid & slot.wb_en & (slot.dest == s). Only sources whose use bit is set and id_valid=1 participate.
- hazard when fwd_en=1: Match(EX, src) & EX.mem_r_en. This is a load-use hazard: exactly one bubble, after which the load sits in MEM and is forwarded from there.
- hazard when fwd_en=0: Match(EX, src) | Match(MEM, src). There is no WB check, because the register file writes on the negative edge.
- Update priority per posedge is rst > freeze > (flush | hazard) > normal.
  - freeze: all slots and stall_count hold.
  - flush or hazard: EX takes a bubble; MEM takes the old EX; WB takes the old MEM.
  - normal: EX takes the ID fields (valid = id_valid); the other slots shift as above.
- Simultaneous flush and hazard: a single bubble; stall_count still increments.
- stall_count increments when hazard=1 and freeze=0, and stops at all-ones.
- Register 0 is an ordinary register; there is no hardwired zero.
- Reset asserted mid-stall: slots clear, so hazard drops in the next cycle.

Decomposition:
- Shared pipeline package holds:
  - REG_W;
  - the slot struct typedef {valid, wb_en, mem_r_en, dest};
  - the BUBBLE constant.
- One sub-module, hazard_match: a combinational slot-versus-source comparator, instantiated four times (EX and MEM × src1 and src2).

Test Plan:
- Load-use: LDR R3 then ADD R4,R3,R1, fwd_en=1 → hazard=1 for exactly 1 cycle; the next cycle shows mem_wb=1, mem_dest=3; stall_count=1.
- No-forward RAW: ADD R2 then SUB R5,R2,R0, fwd_en=0 → hazard=1 for 2 cycles (match in EX, then MEM), 0 when the producer reaches WB; stall_count=2.
- ALU RAW with forwarding: same sequence with fwd_en=1 → hazard never asserts; mem_dest=2 then wb_dest=2 on consecutive cycles.
- Unused source: a MOV with id_use_src1=0 and id_src1 equal to the EX load dest → hazard=0.
- Freeze during a hazard: assert freeze for 3 cycles while hazard=1 → slots and stall_count are unchanged; the bubble is inserted only on the first unfrozen edge.
- Flush plus reset: flush with id_valid=1 → EX becomes a bubble and mem_wb=0 two cycles later; rst mid-stream → all outputs 0 next cycle and stall_count=0.
